// File: rtl/pcileech_board_ctl_if.sv
// Board-pin and status bundle for pcileech_board_ctl.
// The slave modport is the control block; the master modport is the board and core side.
`timescale 1ns / 1ps
interface pcileech_board_ctl_if #(
  parameter int unsigned NUM_BTN = 2,
  parameter int unsigned NUM_LED = 2
) ();
  logic [NUM_BTN-1:0]   btn_n;
  logic [NUM_LED-1:0]   led_in;
  logic [2*NUM_LED-1:0] led_mode;
  logic                 sys_rst;
  logic [63:0]          tickcount;
  logic [NUM_BTN-1:0]   btn_level;
  logic [NUM_BTN-1:0]   btn_press;
  logic [NUM_BTN-1:0]   btn_long;
  logic [NUM_LED-1:0]   led_n;

  modport master (
    output btn_n, led_in, led_mode,
    input  sys_rst, tickcount, btn_level, btn_press, btn_long, led_n
  );

  modport slave (
    input  btn_n, led_in, led_mode,
    output sys_rst, tickcount, btn_level, btn_press, btn_long, led_n
  );
endinterface

// File: rtl/pcileech_board_ctl.sv
// Board control: tick counter, stretched system reset, debounced buttons and LED drive modes.
// Long-press detection is built only when PCILEECH_BOARD_CTL_LONGPRESS_EN is defined.
`timescale 1ns / 1ps
module pcileech_board_ctl #(
  parameter int unsigned NUM_BTN          = 2,
  parameter int unsigned NUM_LED          = 2,
  parameter int unsigned RST_BTN          = 1,
  parameter int unsigned POR_CYCLES       = 64,
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned LONGPRESS_CYCLES = 500000000,
  parameter int unsigned BLINK_BIT        = 24,
  parameter int unsigned PWRON_BIT        = 27
) (
  input  logic                 clk,
  input  logic                 rst,
  pcileech_board_ctl_if.slave  bus
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PorW = $clog2(POR_CYCLES + 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d, level_dly_q, press_q;
  logic [DbW-1:0]     db_cnt_q [NUM_BTN];
  logic [DbW-1:0]     db_cnt_d [NUM_BTN];
  logic [PorW-1:0]    por_q, por_d;
  logic               sys_rst_q;
  logic [63:0]        tick_q, tick_d;
  logic [NUM_LED-1:0] led_n_q, led_n_d;
  logic               rst_btn;
  logic               pwron;

  assign rst_btn = level_q[RST_BTN];

  // A level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          level_d[i] = ~level_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_comb begin
    por_d = por_q;
    if (rst_btn) begin
      por_d = '0;
    end else if (por_q != PorW'(POR_CYCLES)) begin
      por_d = por_q + PorW'(1);
    end
    tick_d = rst_btn ? 64'd0 : tick_q + 64'd1;
  end

  assign pwron = tick_q[BLINK_BIT] & (tick_q[63:PWRON_BIT] == '0);

  always_comb begin
    led_n_d = '1;
    for (int i = 0; i < NUM_LED; i++) begin
      unique case (bus.led_mode[2*i +: 2])
        2'd0: led_n_d[i] = ~bus.led_in[i];
        2'd1: led_n_d[i] = bus.led_in[i];
        2'd2: led_n_d[i] = ~(bus.led_in[i] & tick_q[BLINK_BIT]);
        2'd3: led_n_d[i] = ~(bus.led_in[i] ^ pwron);
        default: led_n_d[i] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
      por_q       <= '0;
      sys_rst_q   <= 1'b1;
      tick_q      <= '0;
      led_n_q     <= '1;
    end else begin
      sync1_q     <= ~bus.btn_n;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      por_q       <= por_d;
      sys_rst_q   <= rst_btn | (por_q < PorW'(POR_CYCLES));
      tick_q      <= tick_d;
      led_n_q     <= led_n_d;
    end
  end

`ifdef PCILEECH_BOARD_CTL_LONGPRESS_EN
  localparam int unsigned HoldW = $clog2(LONGPRESS_CYCLES + 1);

  logic [HoldW-1:0]   hold_q [NUM_BTN];
  logic [HoldW-1:0]   hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] long_q, long_d;

  // Counting needs the level high now and next cycle, so a coincident release suppresses the pulse.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_d[i] = '0;
      long_d[i] = 1'b0;
      if (level_q[i] && level_d[i]) begin
        if (hold_q[i] != HoldW'(LONGPRESS_CYCLES)) begin
          hold_d[i] = hold_q[i] + HoldW'(1);
        end else begin
          hold_d[i] = hold_q[i];
        end
        long_d[i] = (hold_q[i] == HoldW'(LONGPRESS_CYCLES - 1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= '0;
      long_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) hold_q[i] <= hold_d[i];
      long_q <= long_d;
    end
  end

  assign bus.btn_long = long_q;
`else
  assign bus.btn_long = '0;
`endif

  assign bus.sys_rst   = sys_rst_q;
  assign bus.tickcount = tick_q;
  assign bus.btn_level = level_q;
  assign bus.btn_press = press_q;
  assign bus.led_n     = led_n_q;

endmodule

// File: tb/tb_pcileech_board_ctl.sv
// Directed bench for pcileech_board_ctl: expectations are queued before each step and
// checked against the outputs 1 ns after the following clock edge(s).
`timescale 1ns / 1ps
module tb_pcileech_board_ctl;

`ifdef PCILEECH_BOARD_CTL_LONGPRESS_EN
  localparam logic LpEn = 1'b1;
`else
  localparam logic LpEn = 1'b0;
`endif

  localparam int SelRst   = 0;
  localparam int SelTick  = 1;
  localparam int SelLevel = 2;
  localparam int SelPress = 3;
  localparam int SelLong  = 4;
  localparam int SelLed   = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  sb_t         sb_q[$];
  logic [63:0] tk;
  logic [63:0] prev;
  logic        p;

  pcileech_board_ctl_if #(.NUM_BTN(2), .NUM_LED(2)) bus ();

  pcileech_board_ctl #(
    .NUM_BTN         (2),
    .NUM_LED         (2),
    .RST_BTN         (1),
    .POR_CYCLES      (8),
    .DEBOUNCE_CYCLES (4),
    .LONGPRESS_CYCLES(20),
    .BLINK_BIT       (2),
    .PWRON_BIT       (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] obs(input int sel);
    case (sel)
      SelRst:   return {63'd0, bus.sys_rst};
      SelTick:  return bus.tickcount;
      SelLevel: return {62'd0, bus.btn_level};
      SelPress: return {62'd0, bus.btn_press};
      SelLong:  return {62'd0, bus.btn_long};
      default:  return {62'd0, bus.led_n};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    sb_t         e;
    logic [63:0] o;
    repeat (n) @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", e.tag, o, e.exp);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.btn_n    = 2'b11;
    bus.led_in   = 2'b00;
    bus.led_mode = 4'b0000;

    push("rst_sys_rst", SelRst, 64'd1);
    push("rst_tick", SelTick, 64'd0);
    push("rst_level", SelLevel, 64'd0);
    push("rst_press", SelPress, 64'd0);
    push("rst_long", SelLong, 64'd0);
    push("rst_led", SelLed, 64'd3);
    step(3);
    rst = 1'b0;

    for (int k = 1; k <= 12; k++) begin
      push("por_sys_rst", SelRst, (k <= 8) ? 64'd1 : 64'd0);
      push("por_tick", SelTick, 64'(k));
      step(1);
    end
    tk = 64'd12;

    bus.led_in   = 2'b11;
    bus.led_mode = 4'b0000;
    push("led_mode0", SelLed, 64'd0);
    step(1);
    tk++;
    bus.led_mode = 4'b0101;
    push("led_mode1", SelLed, 64'd3);
    step(1);
    tk++;
    bus.led_mode = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      prev = tk;
      push("led_mode2", SelLed, prev[2] ? 64'd0 : 64'd3);
      step(1);
      tk++;
    end
    bus.led_mode = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      prev = tk;
      p = prev[2] & (prev < 64'd32);
      push("led_mode3", SelLed, p ? 64'd3 : 64'd0);
      push("led_tick", SelTick, tk + 64'd1);
      step(1);
      tk++;
    end
    bus.led_in   = 2'b00;
    bus.led_mode = 4'b0000;
    push("led_off", SelLed, 64'd3);
    step(1);

    bus.btn_n = 2'b10;
    step(3);
    bus.btn_n = 2'b11;
    for (int i = 0; i < 10; i++) begin
      push("glitch_level", SelLevel, 64'd0);
      step(1);
    end

    bus.btn_n = 2'b10;
    push("deb_level_early", SelLevel, 64'd0);
    step(5);
    push("deb_level", SelLevel, 64'd1);
    push("deb_press_early", SelPress, 64'd0);
    step(1);
    push("deb_press", SelPress, 64'd1);
    step(1);
    push("deb_press_end", SelPress, 64'd0);
    step(1);
    for (int i = 0; i < 17; i++) begin
      push("long_early", SelLong, 64'd0);
      step(1);
    end
    push("long_pulse", SelLong, {63'd0, LpEn});
    step(1);
    for (int i = 0; i < 14; i++) begin
      push("long_once", SelLong, 64'd0);
      step(1);
    end
    bus.btn_n = 2'b11;
    push("rel_level_held", SelLevel, 64'd1);
    step(5);
    push("rel_level", SelLevel, 64'd0);
    push("rel_press", SelPress, 64'd0);
    step(1);
    step(2);

    for (int rel = 19; rel <= 20; rel++) begin
      bus.btn_n = 2'b10;
      for (int j = 0; j < rel; j++) begin
        push("short_long_held", SelLong, 64'd0);
        step(1);
      end
      bus.btn_n = 2'b11;
      for (int j = 0; j < 12; j++) begin
        push("short_long_rel", SelLong, 64'd0);
        step(1);
      end
      push("short_level", SelLevel, 64'd0);
      step(1);
    end

    bus.btn_n = 2'b10;
    push("mid_level_pre", SelLevel, 64'd1);
    step(15);
    rst = 1'b1;
    push("mid_level", SelLevel, 64'd0);
    push("mid_sys_rst", SelRst, 64'd1);
    push("mid_tick", SelTick, 64'd0);
    step(1);
    rst = 1'b0;
    push("mid_level_wait", SelLevel, 64'd0);
    step(5);
    push("mid_level_back", SelLevel, 64'd1);
    step(1);
    push("mid_press", SelPress, 64'd1);
    step(1);
    for (int i = 0; i < 18; i++) begin
      push("mid_long_early", SelLong, 64'd0);
      step(1);
    end
    push("mid_long", SelLong, {63'd0, LpEn});
    step(1);
    push("mid_long_end", SelLong, 64'd0);
    step(1);
    bus.btn_n = 2'b11;
    step(8);
    push("mid_rel_level", SelLevel, 64'd0);
    step(1);

    bus.btn_n = 2'b01;
    push("rb_sys_rst_pre", SelRst, 64'd0);
    step(5);
    push("rb_level", SelLevel, 64'd2);
    push("rb_sys_rst_edge", SelRst, 64'd0);
    step(1);
    push("rb_press", SelPress, 64'd2);
    push("rb_sys_rst", SelRst, 64'd1);
    push("rb_tick", SelTick, 64'd0);
    step(1);
    for (int i = 0; i < 5; i++) begin
      push("rb_hold_sys_rst", SelRst, 64'd1);
      push("rb_hold_tick", SelTick, 64'd0);
      push("rb_hold_level", SelLevel, 64'd2);
      step(1);
    end
    bus.btn_n = 2'b11;
    push("rb_level_held", SelLevel, 64'd2);
    step(5);
    push("rb_level_rel", SelLevel, 64'd0);
    push("rb_rel_sys_rst", SelRst, 64'd1);
    push("rb_rel_tick", SelTick, 64'd0);
    step(1);
    for (int k = 1; k <= 10; k++) begin
      push("rb_por_sys_rst", SelRst, (k <= 8) ? 64'd1 : 64'd0);
      push("rb_por_tick", SelTick, 64'(k));
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcileech_board_ctl.md
# pcileech_board_ctl

Parametrised board-control block for PCILeech FPGA top levels. It sits between the raw board pins (buttons, LEDs) and the core system, and provides:
- a free-running 64-bit tick counter;
- system-reset generation (reset stretch after reset, plus a dedicated reset button);
- debounced button levels with press and long-press pulses;
- per-LED drive modes, including a power-on blink.

It generalises the per-board tick/reset/LED logic to NUM_BTN buttons and NUM_LED LEDs with runtime-selectable LED modes.

## Interface
- NUM_BTN, 2, number of active-low buttons (1..8)
- NUM_LED, 2, number of active-low LEDs (1..8)
- RST_BTN, 1, index of the button that holds sys_rst
- POR_CYCLES, 64, sys_rst stretch after rst deassert or reset-button release
- DEBOUNCE_CYCLES, 1000000, stable cycles required to accept a button change (≥1)
- LONGPRESS_CYCLES, 500000000, held cycles before a long-press pulse (≥1)
- BLINK_BIT, 24, tickcount bit driving blink
- PWRON_BIT, 27, power-on blink active while tickcount[63:PWRON_BIT]==0
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- btn_n  in  NUM_BTN  raw asynchronous buttons, active-low
- led_in  in  NUM_LED  LED activity request, active-high
- led_mode  in  2*NUM_LED  mode per LED, bits [2i+1:2i]
- sys_rst  out  1  registered system reset, active-high
- tickcount  out  64  tick counter
- btn_level  out  NUM_BTN  debounced pressed state, active-high
- btn_press  out  NUM_BTN  one-cycle pulse on debounced press
- btn_long  out  NUM_BTN  one-cycle pulse on long press
- led_n  out  NUM_LED  LED drive, active-low

## Operation
- Synchroniser: each btn_n bit passes through a 2-FF synchroniser and is inverted to a pressed-high signal. Synchroniser flops reset to 0 (not pressed).
- Debounce, per button:
  - A counter of width $clog2(DEBOUNCE_CYCLES+1) clears whenever the synchronised value equals btn_level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 it toggles btn_level and clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
- btn_press[i] = btn_level rising edge, registered, one cycle.
- Long press, per button:
  - The hold counter clears while btn_level=0 and increments while pressed, saturating at LONGPRESS_CYCLES.
  - btn_long pulses in the single cycle the counter transitions to LONGPRESS_CYCLES. Only one pulse per press; release re-arms.
- Reset stretch: the por counter clears on rst or btn_level[RST_BTN]. Otherwise it increments, saturating at POR_CYCLES.
- sys_rst (registered) = rst | btn_level[RST_BTN] | (por < POR_CYCLES).
- tickcount: 0 on rst or while btn_level[RST_BTN]=1; otherwise +1 per cycle, wraps modulo 2^64.
- pwron = tickcount[BLINK_BIT] & (tickcount[63:PWRON_BIT]==0).
- led_n[i], registered, by mode:
  - 0: ~led_in
  - 1: led_in (inverted)
  - 2: ~(led_in & tickcount[BLINK_BIT])
  - 3: ~(led_in ^ pwron)
- Mode changes take effect on the next cycle; no glitch suppression.

## Timing
- Reset values:
  - sys_rst=1
  - tickcount=0
  - btn_level=0, btn_press=0, btn_long=0
  - led_n all 1 (off)
  - all counters 0
- Button latency: raw edge to btn_level = 2 (sync) + DEBOUNCE_CYCLES cycles. btn_press asserts 1 cycle after btn_level.
- btn_long asserts LONGPRESS_CYCLES cycles after btn_level rises.
- sys_rst deasserts POR_CYCLES+1 cycles after the last cycle with rst=1 or btn_level[RST_BTN]=1.
- LED output: 1 cycle after led_in/led_mode/tickcount change.
- rst mid-press: all debounce, hold and por state clears in that cycle. A button still held when rst drops is re-accepted after a full debounce period, and produces a fresh btn_press.
- Simultaneous release and LONGPRESS_CYCLES reached: release wins; no btn_long pulse.
- Counter saturation: the hold and por counters never wrap.

## Configuration
- PCILEECH_BOARD_CTL_LONGPRESS_EN defined: long-press counters are built and btn_long behaves as specified.
- Not defined: hold counters are removed, btn_long is tied to 0, and all other behaviour is unchanged.

## Test plan
All scenarios use bench parameters NUM_BTN=2, NUM_LED=2, RST_BTN=1, POR_CYCLES=8, DEBOUNCE_CYCLES=4, LONGPRESS_CYCLES=20, BLINK_BIT=2, PWRON_BIT=5.
- Reset stretch: rst high 3 cycles, then low → sys_rst stays 1 for exactly 9 cycles after release, then 0; tickcount counts 1,2,3… from the first cycle after rst.
- Debounce: btn_n[0] low for 3 cycles → btn_level[0] stays 0. Held low → btn_level[0]=1 six cycles after the edge, and btn_press[0] is a single pulse one cycle later.
- Long press: btn_n[0] held low 40 cycles → exactly one btn_long[0] pulse, 20 cycles after btn_level[0] rises. Release 19 cycles after btn_level rises → no pulse. With the macro undefined → btn_long stays 0.
- Reset button: btn_n[1] held low → sys_rst=1 and tickcount=0 while btn_level[1]=1. After debounced release, sys_rst falls 9 cycles later.
- LED modes, with led_in=2'b11:
  - mode 0 → led_n=0
  - mode 1 → led_n=1
  - mode 2 → led_n toggles every 4 cycles
  - mode 3 → blinks only while tickcount<32, then stays 0
- Reset mid-operation: rst pulse while btn_n[0] is held and the hold counter is at 10 → btn_level=0. After rst, btn_level returns to 1 six cycles later with a new btn_press, and btn_long fires 20 cycles after that.
